// File: rtl/dll_pkg.sv
// ============================================================================
// dll_pkg: shared link-state, DLLP type and FC credit definitions for the DLL
// Rev 1.0
// ============================================================================
`default_nettype none

package dll_pkg;

  typedef enum logic [1:0] {
    INACTIVE = 2'b00,
    INIT1    = 2'b01,
    INIT2    = 2'b10,
    ACTIVE   = 2'b11
  } dl_state_e;

  // VC0 DLLP type bytes; the low three bits carry the VC id and are zero here
  localparam logic [7:0] INITFC1_P    = 8'h40;
  localparam logic [7:0] INITFC1_NP   = 8'h50;
  localparam logic [7:0] INITFC1_CPL  = 8'h60;
  localparam logic [7:0] INITFC2_P    = 8'hC0;
  localparam logic [7:0] INITFC2_NP   = 8'hD0;
  localparam logic [7:0] INITFC2_CPL  = 8'hE0;
  localparam logic [7:0] UPDATEFC_P   = 8'h80;
  localparam logic [7:0] UPDATEFC_NP  = 8'h90;
  localparam logic [7:0] UPDATEFC_CPL = 8'hA0;

  localparam logic [1:0] FC_P   = 2'd0;
  localparam logic [1:0] FC_NP  = 2'd1;
  localparam logic [1:0] FC_CPL = 2'd2;

  typedef struct packed {
    logic [7:0]  hdr;
    logic [11:0] data;
  } fc_credit_t;

  function automatic logic [7:0] initfc_type(input logic phase2, input logic [1:0] kind);
    logic [7:0] t;
    t = 8'h00;
    case (kind)
      FC_P:    t = phase2 ? INITFC2_P   : INITFC1_P;
      FC_NP:   t = phase2 ? INITFC2_NP  : INITFC1_NP;
      FC_CPL:  t = phase2 ? INITFC2_CPL : INITFC1_CPL;
      default: t = 8'h00;
    endcase
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dll_fc_capture.sv
// ============================================================================
// dll_fc_capture: decodes received InitFC/UpdateFC DLLPs and latches credits
// Rev 1.0
// ============================================================================
`default_nettype none

module dll_fc_capture
  import dll_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  dl_state,
  input  logic        rx_valid,
  input  logic [7:0]  rx_type,
  input  logic [7:0]  rx_hdrfc,
  input  logic [11:0] rx_datafc,
  output fc_credit_t  fc_p,
  output fc_credit_t  fc_np,
  output fc_credit_t  fc_cpl,
  output logic        initfc_received,
  output logic        initfc2_received
);

  dl_state_e  w_dl;
  fc_credit_t w_rx_cred;
  logic       w_is_p;
  logic       w_is_np;
  logic       w_is_cpl;
  logic       w_init2_evt;

  logic       r_recv_p;
  logic       r_recv_np;
  logic       r_recv_cpl;
  logic       r_received;
  logic       r_received2;
  fc_credit_t r_fc_p;
  fc_credit_t r_fc_np;
  fc_credit_t r_fc_cpl;

  assign w_dl      = dl_state_e'(dl_state);
  assign w_rx_cred = '{hdr: rx_hdrfc, data: rx_datafc};

  // Whole-byte compares also reject any nonzero VC bits
  assign w_is_p      = rx_valid & ((rx_type == INITFC1_P)   | (rx_type == INITFC2_P));
  assign w_is_np     = rx_valid & ((rx_type == INITFC1_NP)  | (rx_type == INITFC2_NP));
  assign w_is_cpl    = rx_valid & ((rx_type == INITFC1_CPL) | (rx_type == INITFC2_CPL));
  assign w_init2_evt = rx_valid & ((rx_type == INITFC2_P)   | (rx_type == INITFC2_NP)  |
                                   (rx_type == INITFC2_CPL) | (rx_type == UPDATEFC_P) |
                                   (rx_type == UPDATEFC_NP) | (rx_type == UPDATEFC_CPL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_recv_p    <= 1'b0;
      r_recv_np   <= 1'b0;
      r_recv_cpl  <= 1'b0;
      r_received  <= 1'b0;
      r_received2 <= 1'b0;
      r_fc_p      <= '0;
      r_fc_np     <= '0;
      r_fc_cpl    <= '0;
    end else if (w_dl == INACTIVE) begin
      r_recv_p    <= 1'b0;
      r_recv_np   <= 1'b0;
      r_recv_cpl  <= 1'b0;
      r_received  <= 1'b0;
      r_received2 <= 1'b0;
      r_fc_p      <= '0;
      r_fc_np     <= '0;
      r_fc_cpl    <= '0;
    end else begin
      r_received <= r_recv_p & r_recv_np & r_recv_cpl;
      if (w_dl == INIT1) begin
        if (w_is_p && !r_recv_p) begin
          r_fc_p   <= w_rx_cred;
          r_recv_p <= 1'b1;
        end
        if (w_is_np && !r_recv_np) begin
          r_fc_np   <= w_rx_cred;
          r_recv_np <= 1'b1;
        end
        if (w_is_cpl && !r_recv_cpl) begin
          r_fc_cpl   <= w_rx_cred;
          r_recv_cpl <= 1'b1;
        end
      end else if (w_dl == INIT2) begin
        if (w_init2_evt) begin
          r_received2 <= 1'b1;
        end
      end
    end
  end

  assign fc_p             = r_fc_p;
  assign fc_np            = r_fc_np;
  assign fc_cpl           = r_fc_cpl;
  assign initfc_received  = r_received;
  assign initfc2_received = r_received2;

endmodule

`default_nettype wire

// File: rtl/dll_initfc_ctrl.sv
// ============================================================================
// dll_initfc_ctrl: VC0 flow-control init sequencer (InitFC1/InitFC2 tx + rx)
// Rev 1.0
// ============================================================================
`default_nettype none

module dll_initfc_ctrl
  import dll_pkg::*;
#(
  parameter logic [7:0]  P_HDR_FC      = 8'd32,
  parameter logic [11:0] P_DATA_FC     = 12'd256,
  parameter logic [7:0]  NP_HDR_FC     = 8'd32,
  parameter logic [11:0] NP_DATA_FC    = 12'd64,
  parameter logic [7:0]  CPL_HDR_FC    = 8'd0,
  parameter logic [11:0] CPL_DATA_FC   = 12'd0,
  parameter int          RESEND_CYCLES = 8500
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  dl_state_i,
  output logic        tx_dllp_valid_o,
  input  logic        tx_dllp_ready_i,
  output logic [7:0]  tx_dllp_type_o,
  output logic [7:0]  tx_hdrfc_o,
  output logic [11:0] tx_datafc_o,
  input  logic        rx_dllp_valid_i,
  input  logic [7:0]  rx_dllp_type_i,
  input  logic [7:0]  rx_hdrfc_i,
  input  logic [11:0] rx_datafc_i,
  output logic        initfc_sent_o,
  output logic        initfc_received_o,
  output logic        initfc2_sent_o,
  output logic        initfc2_received_o,
  output logic [7:0]  fc_p_hdr_o,
  output logic [7:0]  fc_np_hdr_o,
  output logic [7:0]  fc_cpl_hdr_o,
  output logic [11:0] fc_p_data_o,
  output logic [11:0] fc_np_data_o,
  output logic [11:0] fc_cpl_data_o
);

  localparam int              CNT_W    = $clog2(RESEND_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESEND_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RESEND_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SEND_P   = 3'd1;
  localparam logic [2:0] ST_SEND_NP  = 3'd2;
  localparam logic [2:0] ST_SEND_CPL = 3'd3;
  localparam logic [2:0] ST_WAIT     = 3'd4;

  logic [2:0]       r_state;
  logic             r_phase2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sent1;
  logic             r_sent2;

  dl_state_e  w_dl;
  logic       w_sending;
  logic [1:0] w_kind;
  logic       w_hs;
  logic       w_to_init2;
  fc_credit_t w_cred;
  fc_credit_t w_fc_p;
  fc_credit_t w_fc_np;
  fc_credit_t w_fc_cpl;

  assign w_dl = dl_state_e'(dl_state_i);

  always_comb begin
    w_sending = 1'b0;
    w_kind    = FC_P;
    case (r_state)
      ST_SEND_P:   begin w_sending = 1'b1; w_kind = FC_P;   end
      ST_SEND_NP:  begin w_sending = 1'b1; w_kind = FC_NP;  end
      ST_SEND_CPL: begin w_sending = 1'b1; w_kind = FC_CPL; end
      default:     begin w_sending = 1'b0; w_kind = FC_P;   end
    endcase
  end

  always_comb begin
    w_cred = '0;
    if (w_sending) begin
      case (w_kind)
        FC_P:    w_cred = '{hdr: P_HDR_FC,   data: P_DATA_FC};
        FC_NP:   w_cred = '{hdr: NP_HDR_FC,  data: NP_DATA_FC};
        FC_CPL:  w_cred = '{hdr: CPL_HDR_FC, data: CPL_DATA_FC};
        default: w_cred = '0;
      endcase
    end
  end

  assign tx_dllp_valid_o = w_sending;
  assign tx_dllp_type_o  = w_sending ? initfc_type(r_phase2, w_kind) : 8'h00;
  assign tx_hdrfc_o      = w_cred.hdr;
  assign tx_datafc_o     = w_cred.data;

  assign w_hs       = w_sending & tx_dllp_ready_i;
  assign w_to_init2 = (w_dl == INIT2) & ~r_phase2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_phase2 <= 1'b0;
      r_cnt    <= '0;
      r_sent1  <= 1'b0;
      r_sent2  <= 1'b0;
    end else if (w_dl == INACTIVE) begin
      r_state  <= ST_IDLE;
      r_phase2 <= 1'b0;
      r_cnt    <= '0;
      r_sent1  <= 1'b0;
      r_sent2  <= 1'b0;
    end else begin
      if (w_hs && (r_state == ST_SEND_CPL)) begin
        if (r_phase2) r_sent2 <= 1'b1;
        else          r_sent1 <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_dl == INIT1) begin
            r_state  <= ST_SEND_P;
            r_phase2 <= 1'b0;
          end else if (w_dl == INIT2) begin
            r_state  <= ST_SEND_P;
            r_phase2 <= 1'b1;
          end
        end
        ST_SEND_P, ST_SEND_NP, ST_SEND_CPL: begin
          // The in-flight DLLP always finishes; link-state changes act on the next one
          if (w_hs) begin
            if (w_dl == ACTIVE) begin
              r_state <= ST_IDLE;
            end else if (w_to_init2) begin
              r_state  <= ST_SEND_P;
              r_phase2 <= 1'b1;
            end else if (r_state == ST_SEND_P) begin
              r_state <= ST_SEND_NP;
            end else if (r_state == ST_SEND_NP) begin
              r_state <= ST_SEND_CPL;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= '0;
            end
          end
        end
        ST_WAIT: begin
          if (w_dl == ACTIVE) begin
            r_state <= ST_IDLE;
          end else if (w_to_init2) begin
            r_state  <= ST_SEND_P;
            r_phase2 <= 1'b1;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_SEND_P;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  dll_fc_capture u_capture (
    .clk              (clk),
    .rst_n            (rst_n),
    .dl_state         (dl_state_i),
    .rx_valid         (rx_dllp_valid_i),
    .rx_type          (rx_dllp_type_i),
    .rx_hdrfc         (rx_hdrfc_i),
    .rx_datafc        (rx_datafc_i),
    .fc_p             (w_fc_p),
    .fc_np            (w_fc_np),
    .fc_cpl           (w_fc_cpl),
    .initfc_received  (initfc_received_o),
    .initfc2_received (initfc2_received_o)
  );

  assign initfc_sent_o  = r_sent1;
  assign initfc2_sent_o = r_sent2;
  assign fc_p_hdr_o     = w_fc_p.hdr;
  assign fc_p_data_o    = w_fc_p.data;
  assign fc_np_hdr_o    = w_fc_np.hdr;
  assign fc_np_data_o   = w_fc_np.data;
  assign fc_cpl_hdr_o   = w_fc_cpl.hdr;
  assign fc_cpl_data_o  = w_fc_cpl.data;

endmodule

`default_nettype wire

// File: tb/tb_dll_initfc_ctrl.sv
// ============================================================================
// tb_dll_initfc_ctrl: directed self-checking bench for dll_initfc_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dll_initfc_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  dl_state;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_type;
  logic [7:0]  tx_hdr;
  logic [11:0] tx_data;
  logic        rx_valid;
  logic [7:0]  rx_type;
  logic [7:0]  rx_hdr;
  logic [11:0] rx_data;
  logic        sent1;
  logic        recv1;
  logic        sent2;
  logic        recv2;
  logic [7:0]  p_hdr;
  logic [7:0]  np_hdr;
  logic [7:0]  cpl_hdr;
  logic [11:0] p_data;
  logic [11:0] np_data;
  logic [11:0] cpl_data;

  int vectors;
  int miscompares;

  dll_initfc_ctrl #(
    .RESEND_CYCLES (16)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .dl_state_i         (dl_state),
    .tx_dllp_valid_o    (tx_valid),
    .tx_dllp_ready_i    (tx_ready),
    .tx_dllp_type_o     (tx_type),
    .tx_hdrfc_o         (tx_hdr),
    .tx_datafc_o        (tx_data),
    .rx_dllp_valid_i    (rx_valid),
    .rx_dllp_type_i     (rx_type),
    .rx_hdrfc_i         (rx_hdr),
    .rx_datafc_i        (rx_data),
    .initfc_sent_o      (sent1),
    .initfc_received_o  (recv1),
    .initfc2_sent_o     (sent2),
    .initfc2_received_o (recv2),
    .fc_p_hdr_o         (p_hdr),
    .fc_np_hdr_o        (np_hdr),
    .fc_cpl_hdr_o       (cpl_hdr),
    .fc_p_data_o        (p_data),
    .fc_np_data_o       (np_data),
    .fc_cpl_data_o      (cpl_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rx(input logic [7:0] t, input logic [7:0] h, input logic [11:0] d);
    rx_valid = 1'b1;
    rx_type  = t;
    rx_hdr   = h;
    rx_data  = d;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle;
    int hi;
    vectors     = 0;
    miscompares = 0;
    rst_n    = 1'b0;
    dl_state = 2'b00;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_type  = 8'h00;
    rx_hdr   = 8'h00;
    rx_data  = 12'h000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_fields", {4'd0, tx_type, tx_hdr, tx_data}, 32'd0);
    chk("rst_flags", {28'd0, sent1, recv1, sent2, recv2}, 32'd0);
    chk("rst_hdrs", {8'd0, p_hdr, np_hdr, cpl_hdr}, 32'd0);
    chk("rst_data", {8'd0, p_data, np_data}, 32'd0);

    rst_n = 1'b1;
    tick();
    chk("inactive_idle", {31'd0, tx_valid}, 32'd0);

    // InitFC1 sequence with the arbiter always ready
    dl_state = 2'b01;
    tx_ready = 1'b1;
    tick();
    chk("i1_p", {tx_valid, tx_type, tx_hdr, tx_data}, {1'b1, 8'h40, 8'd32, 12'd256});
    tick();
    chk("i1_np", {tx_valid, tx_type, tx_hdr, tx_data}, {1'b1, 8'h50, 8'd32, 12'd64});
    tick();
    chk("i1_cpl", {tx_valid, tx_type, tx_hdr, tx_data}, {1'b1, 8'h60, 8'd0, 12'd0});
    chk("i1_sent_early", {31'd0, sent1}, 32'd0);
    tick();
    chk("i1_sent", {31'd0, sent1}, 32'd1);
    chk("i1_wait_idle", {31'd0, tx_valid}, 32'd0);
    idle = 0;
    while (!tx_valid && idle < 100) begin
      idle++;
      tick();
    end
    chk("resend_gap", idle, 32'd16);
    chk("resend_type", {24'd0, tx_type}, 32'h40);

    // Hold P stalled while partner InitFCs arrive
    tx_ready = 1'b0;
    rx(8'h50, 8'd5, 12'd9);
    rx(8'h40, 8'd7, 12'd100);
    rx(8'h40, 8'd1, 12'd1);
    rx(8'h61, 8'd9, 12'd9);
    rx(8'hE0, 8'd0, 12'd0);
    chk("recv_not_yet", {31'd0, recv1}, 32'd0);
    tick();
    chk("recv_all", {31'd0, recv1}, 32'd1);
    chk("fc_p", {12'd0, p_hdr, p_data}, {12'd0, 8'd7, 12'd100});
    chk("fc_np", {12'd0, np_hdr, np_data}, {12'd0, 8'd5, 12'd9});
    chk("fc_cpl", {12'd0, cpl_hdr, cpl_data}, 32'd0);
    chk("p_stalled", {tx_valid, tx_type, tx_hdr, tx_data}, {1'b1, 8'h40, 8'd32, 12'd256});

    // Stall NP and switch to INIT2 during the stall
    tx_ready = 1'b1;
    tick();
    chk("np_start", {tx_valid, tx_type, tx_hdr, tx_data}, {1'b1, 8'h50, 8'd32, 12'd64});
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) dl_state = 2'b10;
      tick();
      chk("np_stable", {tx_valid, tx_type, tx_hdr, tx_data}, {1'b1, 8'h50, 8'd32, 12'd64});
    end
    tx_ready = 1'b1;
    tick();
    chk("i2_first", {tx_valid, tx_type, tx_hdr, tx_data}, {1'b1, 8'hC0, 8'd32, 12'd256});
    chk("recv2_clear", {31'd0, recv2}, 32'd0);

    tx_ready = 1'b0;
    rx(8'h90, 8'd50, 12'd50);
    chk("recv2_set", {31'd0, recv2}, 32'd1);
    chk("np_held", {12'd0, np_hdr, np_data}, {12'd0, 8'd5, 12'd9});

    tx_ready = 1'b1;
    tick();
    chk("i2_np", {tx_valid, tx_type, tx_hdr, tx_data}, {1'b1, 8'hD0, 8'd32, 12'd64});
    tick();
    chk("i2_cpl", {tx_valid, tx_type, tx_hdr, tx_data}, {1'b1, 8'hE0, 8'd0, 12'd0});
    chk("sent2_early", {31'd0, sent2}, 32'd0);
    tick();
    chk("sent2", {31'd0, sent2}, 32'd1);
    chk("i2_wait_idle", {31'd0, tx_valid}, 32'd0);

    // ACTIVE: no further InitFC, everything holds
    dl_state = 2'b11;
    hi = 0;
    repeat (40) begin
      tick();
      if (tx_valid) hi++;
    end
    chk("active_quiet", hi, 32'd0);
    chk("active_flags", {28'd0, sent1, recv1, sent2, recv2}, 32'hF);
    chk("active_fc_p", {12'd0, p_hdr, p_data}, {12'd0, 8'd7, 12'd100});

    // INACTIVE mid-NP with a simultaneous rx Cpl
    dl_state = 2'b01;
    tick();
    chk("re_p", {tx_valid, tx_type}, {1'b1, 8'h40});
    tick();
    chk("re_np", {tx_valid, tx_type}, {1'b1, 8'h50});
    dl_state = 2'b00;
    rx(8'h60, 8'd5, 12'd5);
    chk("down_valid", {31'd0, tx_valid}, 32'd0);
    chk("down_flags", {28'd0, sent1, recv1, sent2, recv2}, 32'd0);
    chk("down_fc_p", {12'd0, p_hdr, p_data}, 32'd0);
    chk("down_fc_np", {12'd0, np_hdr, np_data}, 32'd0);
    chk("down_fc_cpl", {12'd0, cpl_hdr, cpl_data}, 32'd0);
    tick();
    chk("down_idle", {31'd0, tx_valid}, 32'd0);
    dl_state = 2'b01;
    tick();
    chk("restart_p", {tx_valid, tx_type, tx_hdr, tx_data}, {1'b1, 8'h40, 8'd32, 12'd256});

    // Async reset in the middle of WAIT
    tick();
    tick();
    tick();
    chk("pre_rst_sent", {31'd0, sent1}, 32'd1);
    repeat (3) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_flags", {28'd0, sent1, recv1, sent2, recv2}, 32'd0);
    chk("arst_valid", {31'd0, tx_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("arst_restart", {tx_valid, tx_type, tx_hdr, tx_data}, {1'b1, 8'h40, 8'd32, 12'd256});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dll_initfc_ctrl.md
Name: dll_initfc_ctrl

Overview:
- Sequences PCIe DLL flow-control initialisation for VC0 alongside the data-link control state machine.
- Transmits the InitFC1 and then InitFC2 DLLP sequences (P, NP, Cpl).
- Decodes received InitFC and UpdateFC DLLPs, latches the partner's advertised credits, and drives the sent/received handshake flags the state machine uses to advance INIT1 -> INIT2 -> ACTIVE.

Parameters:
- P_HDR_FC, 8'd32, advertised posted header credits (0 = infinite).
- P_DATA_FC, 12'd256, advertised posted data credits (0 = infinite).
- NP_HDR_FC, 8'd32, advertised non-posted header credits.
- NP_DATA_FC, 12'd64, advertised non-posted data credits.
- CPL_HDR_FC, 8'd0, advertised completion header credits.
- CPL_DATA_FC, 12'd0, advertised completion data credits.
- RESEND_CYCLES, 8500, idle cycles between repeated sequences (34 us at 250 MHz); must be >= 1.

Ports:
- clk  in  1  clock; one clock.
- rst_n  in  1  asynchronous, active-low reset.
- dl_state_i  in  2  link state: 00 INACTIVE, 01 INIT1, 10 INIT2, 11 ACTIVE.
- tx_dllp_valid_o  out  1  outgoing InitFC DLLP valid.
- tx_dllp_ready_i  in  1  DLLP transmit arbiter accepts.
- tx_dllp_type_o  out  8  DLLP type byte.
- tx_hdrfc_o  out  8  HdrFC field.
- tx_datafc_o  out  12  DataFC field.
- rx_dllp_valid_i  in  1  received, CRC-checked DLLP strobe (one cycle).
- rx_dllp_type_i  in  8  received type byte.
- rx_hdrfc_i  in  8  received HdrFC.
- rx_datafc_i  in  12  received DataFC.
- initfc_sent_o  out  1  one full InitFC1 sequence sent.
- initfc_received_o  out  1  InitFC for P, NP and Cpl all recorded.
- initfc2_sent_o  out  1  one full InitFC2 sequence sent.
- initfc2_received_o  out  1  InitFC2 or UpdateFC received in INIT2.
- fc_p_hdr_o, fc_np_hdr_o, fc_cpl_hdr_o  out  8 each  latched partner header credits.
- fc_p_data_o, fc_np_data_o, fc_cpl_data_o  out  12 each  latched partner data credits.

Behaviour:
- Reset: all outputs 0, tx FSM in IDLE, phase = INIT1, resend counter 0.
- Type encodings (VC0, low 3 bits 000):
  - InitFC1: P 0x40, NP 0x50, Cpl 0x60.
  - InitFC2: P 0xC0, NP 0xD0, Cpl 0xE0.
  - UpdateFC: P 0x80, NP 0x90, Cpl 0xA0.
  - Any other type, or nonzero VC bits, is ignored.
- Tx FSM states: IDLE, SEND_P, SEND_NP, SEND_CPL, WAIT.
- IDLE:
  - dl_state_i == INIT1 -> SEND_P with phase INIT1.
  - dl_state_i == INIT2 -> SEND_P with phase INIT2.
- SEND_x:
  - valid = 1; type, hdr and data come from the phase and the matching parameters.
  - Each advances on the valid & ready cycle: P -> NP -> CPL -> WAIT.
  - Fields are stable while valid & !ready.
- Completing a SEND_CPL handshake sets initfc_sent_o (phase INIT1) or initfc2_sent_o (phase INIT2). Both flags are sticky.
- WAIT:
  - Counts RESEND_CYCLES cycles, then -> SEND_P. The sequence repeats for as long as dl_state is INIT1 or INIT2.
  - If dl_state_i changes from INIT1 to INIT2 during WAIT, go -> SEND_P immediately with phase INIT2.
- INIT1 -> INIT2 change during SEND_x: the in-flight DLLP completes unchanged. The next DLLP is SEND_P with phase INIT2; the INIT1 sequence is not finished.
- dl_state_i == ACTIVE: after any in-flight handshake, go to IDLE. No further InitFC is sent. Flags and credits hold.
- dl_state_i == INACTIVE (highest priority, any state):
  - Next cycle: valid drops (abort allowed; arbiter flushes on link down), FSM -> IDLE, phase = INIT1, counter 0.
  - All four flags and all credit registers clear.
  - This beats any simultaneous rx event.
- Rx, INIT1:
  - InitFC1 or InitFC2 of type x, first occurrence: latch hdr/data into fc_x and set recv_x. Later occurrences for that type are ignored.
  - initfc_received_o = recv_p & recv_np & recv_cpl, registered one cycle after the last capture.
- Rx, INIT2:
  - Any InitFC2 or UpdateFC sets initfc2_received_o the next cycle.
  - Credits are not re-latched.
- Rx, ACTIVE/INACTIVE: ignored by this block.
- Counter width is $clog2(RESEND_CYCLES+1); no wrap, it saturates and reloads on entry to WAIT.

Decomposition:
- dll_pkg holds:
  - dl_state_e enum (INACTIVE/INIT1/INIT2/ACTIVE), shared with the state machine;
  - DLLP type localparams (INITFC1_P ... UPDATEFC_CPL);
  - fc_credit_t struct {hdr[7:0], data[11:0]}.
- Sub-module dll_fc_capture: rx decode, recv_x bits, credit registers and the two received flags.
- The top holds the tx FSM and resend counter.

Test Plan:
- Reset, then dl_state = INIT1 with ready = 1 -> types 0x40, 0x50, 0x60 on consecutive cycles with hdr/data 32/256, 32/64, 0/0. initfc_sent_o = 1 the cycle after the 0x60 handshake. Repeat after exactly RESEND_CYCLES (bench uses 16).
- In INIT1, rx 0x50 (NP 5/9), 0x40 (P 7/100), then 0x40 (P 1/1), then 0xE0 (Cpl 0/0):
  - fc_p = 7/100, since the second P is ignored;
  - fc_np = 5/9;
  - initfc_received_o rises one cycle after 0xE0.
- Ready held low 5 cycles on 0x50 -> valid and fields stable. Switch dl_state to INIT2 during the stall -> 0x50 completes, next DLLP is 0xC0.
- INIT2: rx 0x90 (UpdateFC NP) -> initfc2_received_o = 1 next cycle, credits unchanged. Full 0xC0/0xD0/0xE0 sequence -> initfc2_sent_o = 1. dl_state = ACTIVE -> no further valid.
- dl_state -> INACTIVE mid-SEND_NP, with rx 0x60 on the same cycle -> next cycle valid = 0, all flags and credits 0, no capture. Re-entering INIT1 restarts at 0x40.
- Async rst_n pulse mid-WAIT -> all outputs 0 immediately. After release with INIT1, the sequence starts at 0x40.
